counter_datapath: RTL and testbench

- Datapath slave of the counter CPU. It executes the control unit's per-cycle commands (ASrcMuxSel, ALoad, OutPort) on accumulator register A.
- It returns the ALt10 status back to the control unit.
- Values issued by OutPort go to a downstream consumer through a valid/ready output stage with overrun detection.
- Sits between the control FSM and the board-level display/port logic.

---
 rtl/counter_pkg.sv | 12 +
 rtl/counter_datapath_if.sv | 21 ++
 rtl/counter_out_stage.sv | 53 +++++
 rtl/counter_datapath.sv | 30 +++
 tb/tb_counter_datapath.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared constants for the counter CPU datapath, control unit and bench monitors
package counter_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_LIMIT = 10;
  localparam logic SRC_ZERO = 1'b0;
  localparam logic SRC_INC = 1'b1;
  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;
endpackage

// File: rtl/counter_datapath_if.sv
// counter_datapath_if: command/status and valid/ready output bundle between control side and datapath
interface counter_datapath_if import counter_pkg::*; #(parameter int WIDTH = DEF_WIDTH) ();
  logic ASrcMuxSel;
  logic ALoad;
  logic OutPort;
  logic ALt10;
  logic [WIDTH-1:0] a_value;
  logic [WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic ovr_clr;
  logic out_overrun;
  modport master (
    output ASrcMuxSel, ALoad, OutPort, out_ready, ovr_clr,
    input ALt10, a_value, out_data, out_valid, out_overrun
  );
  modport slave (
    input ASrcMuxSel, ALoad, OutPort, out_ready, ovr_clr,
    output ALt10, a_value, out_data, out_valid, out_overrun
  );
endinterface

// File: rtl/counter_out_stage.sv
// counter_out_stage: valid/ready output stage with sticky overrun; 4-deep FIFO when COUNTER_DP_FIFO_EN is defined
module counter_out_stage #(parameter int WIDTH = 8) (
  input  logic clk,
  input  logic reset,
  input  logic capture,
  input  logic [WIDTH-1:0] din,
  input  logic ready,
  input  logic ovr_clr,
  output logic [WIDTH-1:0] data,
  output logic valid,
  output logic overrun
);
  logic ovr_set;
`ifdef COUNTER_DP_FIFO_EN
  logic [WIDTH-1:0] mem [4];
  logic [1:0] head, tail;
  logic [2:0] count;
  logic pop, push;
  assign pop = (count != 3'd0) && ready;
  assign push = capture && ((count != 3'd4) || pop);
  assign ovr_set = capture && (count == 3'd4) && !pop;
  assign data = mem[head];
  assign valid = count != 3'd0;
  // circular buffer: push at tail, pop at head; a full FIFO may push and pop in one edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) mem[tail] <= din;
      if (push) tail <= tail + 2'd1;
      if (pop) head <= head + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
`else
  assign ovr_set = capture && valid && !ready;
  // single holding register: a capture always loads, even over unconsumed data
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      data <= '0;
      valid <= 1'b0;
    end else if (capture) begin
      data <= din;
      valid <= 1'b1;
    end else if (valid && ready) valid <= 1'b0;
`endif
  // sticky overrun flag, a new event beats a simultaneous clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) overrun <= 1'b0;
    else overrun <= ovr_set || (overrun && !ovr_clr);
endmodule

// File: rtl/counter_datapath.sv
// counter_datapath: accumulator A with zero/increment mux, A<LIMIT status and output stage (COUNTER_DP_FIFO_EN selects FIFO stage)
module counter_datapath import counter_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LIMIT = DEF_LIMIT,
  parameter int STEP = 1
) (
  input logic clk,
  input logic reset,
  counter_datapath_if.slave bus
);
  logic [WIDTH-1:0] a, a_src;
  assign a_src = (bus.ASrcMuxSel == SRC_INC) ? a + WIDTH'(STEP) : '0;
  assign bus.a_value = a;
  assign bus.ALt10 = a < WIDTH'(LIMIT);
  // accumulator loads the mux result when enabled, increment wraps at WIDTH bits
  always_ff @(posedge clk or negedge reset)
    if (!reset) a <= '0;
    else if (bus.ALoad) a <= a_src;
  counter_out_stage #(.WIDTH(WIDTH)) u_out (
    .clk(clk),
    .reset(reset),
    .capture(bus.OutPort),
    .din(a),
    .ready(bus.out_ready),
    .ovr_clr(bus.ovr_clr),
    .data(bus.out_data),
    .valid(bus.out_valid),
    .overrun(bus.out_overrun)
  );
endmodule

// File: tb/tb_counter_datapath.sv
// tb_counter_datapath: randomized scoreboard bench with a queue-based reference model of A and the output stage
module tb_counter_datapath;
  import counter_pkg::*;
  localparam int W = 8;
  localparam int LIM = 10;
  localparam int STP = 1;
`ifdef COUNTER_DP_FIFO_EN
  localparam int CAP = 4;
  localparam int OVR_START = 1;
  localparam int OVR_N = 5;
  localparam int OVR_HEAD = 1;
`else
  localparam int CAP = 1;
  localparam int OVR_START = 5;
  localparam int OVR_N = 2;
  localparam int OVR_HEAD = 6;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  counter_datapath_if #(.WIDTH(W)) dif ();
  counter_datapath_if #(.WIDTH(4)) dif4 ();
  counter_datapath #(.WIDTH(W), .LIMIT(LIM), .STEP(STP)) dut (.clk(clk), .reset(reset), .bus(dif.slave));
  counter_datapath #(.WIDTH(4), .LIMIT(LIM), .STEP(1)) dut4 (.clk(clk), .reset(reset), .bus(dif4.slave));
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int ma = 0;
  int n = 0;
  bit movr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (reset && dif.out_valid && dif.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer: got %0d expected no transfer", dif.out_data);
      end else chk("xfer", int'(dif.out_data), exp_q.pop_front());
    end

  task automatic step(input bit sel, input bit ld, input bit op, input bit rdy, input bit clr);
    bit pop, full_drop;
    chk("a_value", int'(dif.a_value), ma);
    chk("alt10", int'(dif.ALt10), int'(ma < LIM));
    chk("valid", int'(dif.out_valid), int'(n > 0));
    chk("overrun", int'(dif.out_overrun), int'(movr));
    dif.ASrcMuxSel = sel;
    dif.ALoad = ld;
    dif.OutPort = op;
    dif.out_ready = rdy;
    dif.ovr_clr = clr;
    pop = (n > 0) && rdy;
    full_drop = op && (n == CAP) && !pop;
    if (op) begin
      if (!full_drop) exp_q.push_back(ma);
      else if (CAP == 1) exp_q[exp_q.size()-1] = ma;
    end
    n = n - int'(pop) + int'(op && !full_drop);
    movr = full_drop || (movr && !clr);
    if (ld) ma = sel ? (ma + STP) % (1 << W) : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic count_to(input int v);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < v; i++) step(1, 1, 0, 0, 0);
  endtask

  initial begin
    dif.ASrcMuxSel = 0; dif.ALoad = 0; dif.OutPort = 0; dif.out_ready = 0; dif.ovr_clr = 0;
    dif4.ASrcMuxSel = 0; dif4.ALoad = 0; dif4.OutPort = 0; dif4.out_ready = 0; dif4.ovr_clr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    count_to(10);
    step(0, 0, 0, 0, 0);
    chk("alt10_at_limit", int'(dif.ALt10), 0);
    count_to(3);
    step(1, 1, 1, 0, 0);
    chk("cap_data", int'(dif.out_data), 3);
    chk("cap_a", int'(dif.a_value), 4);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    count_to(OVR_START);
    for (int i = 0; i < OVR_N; i++) step(1, 1, 1, 0, 0);
    chk("ovr_head", int'(dif.out_data), OVR_HEAD);
    chk("ovr_flag", int'(dif.out_overrun), 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 8 && dif.out_valid; i++) step(0, 0, 0, 1, 0);
    chk("drained", int'(dif.out_valid), 0);
    chk("drain_q", exp_q.size(), 0);
    count_to(7);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("rst_a", int'(dif.a_value), 0);
    chk("rst_alt", int'(dif.ALt10), 1);
    chk("rst_valid", int'(dif.out_valid), 0);
    chk("rst_ovr", int'(dif.out_overrun), 0);
    dif.OutPort = 0;
    ma = 0; n = 0; movr = 0;
    exp_q.delete();
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    dif4.ALoad = 1;
    dif4.ASrcMuxSel = 0;
    @(posedge clk);
    #1;
    dif4.ASrcMuxSel = 1;
    repeat (15) @(posedge clk);
    #1;
    chk("w4_max", int'(dif4.a_value), 15);
    chk("w4_max_alt", int'(dif4.ALt10), 0);
    @(posedge clk);
    #1;
    dif4.ALoad = 0;
    chk("w4_wrap", int'(dif4.a_value), 0);
    chk("w4_wrap_alt", int'(dif4.ALt10), 1);
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
    chk("final_q", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
